// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer for the conv -> relu/pool -> fc inference pipeline: one go/ack job per unit of work.
// Optional macro SEQ_PERF_CNT_EN adds a saturating per-inference cycle counter on perf_cycles.
module cnn_layer_sequencer #(
    parameter int INPUT_SIZE       = 28,
    parameter int CONV_FILTER_SIZE = 7,
    parameter int CONV_NUM_FILTERS = 16,
    parameter int CONV_STRIDE      = 3,
    parameter int POOLING_SIZE     = 2,
    parameter int FC_NUM_OUTPUTS   = 10
) (
    input  logic clk,
    input  logic rstb,
    input  logic start,
    output logic busy,
    output logic done,
    output logic conv_go,
    input  logic conv_ack,
    output logic [$clog2(CONV_NUM_FILTERS)-1:0] conv_filter_idx,
    output logic [$clog2((INPUT_SIZE-CONV_FILTER_SIZE)/CONV_STRIDE+1)-1:0] conv_row,
    output logic [$clog2((INPUT_SIZE-CONV_FILTER_SIZE)/CONV_STRIDE+1)-1:0] conv_col,
    output logic [$clog2(INPUT_SIZE*INPUT_SIZE)-1:0] conv_base_addr,
    output logic pool_go,
    input  logic pool_ack,
    output logic [$clog2(CONV_NUM_FILTERS)-1:0] pool_filter_idx,
    output logic fc_go,
    input  logic fc_ack,
    output logic [$clog2(FC_NUM_OUTPUTS)-1:0] fc_neuron_idx,
    output logic [31:0] perf_cycles
);
    localparam int CONV_OUT = (INPUT_SIZE-CONV_FILTER_SIZE)/CONV_STRIDE+1;
    localparam int POOL_OUT = (CONV_OUT-POOLING_SIZE)/POOLING_SIZE+1;
    localparam int AW = $clog2(INPUT_SIZE*INPUT_SIZE);
    localparam int FW = $clog2(CONV_NUM_FILTERS);
    localparam int RW = $clog2(CONV_OUT);
    localparam int NW = $clog2(FC_NUM_OUTPUTS);

    localparam logic [FW-1:0] FILTER_LAST = FW'(CONV_NUM_FILTERS-1);
    localparam logic [RW-1:0] POS_LAST    = RW'(CONV_OUT-1);
    localparam logic [NW-1:0] NEURON_LAST = NW'(FC_NUM_OUTPUTS-1);
    localparam logic [FW-1:0] FILTER_ONE  = {{(FW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] POS_ONE     = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] NEURON_ONE  = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ROW_STEP    = AW'(CONV_STRIDE*INPUT_SIZE);
    localparam logic [AW-1:0] COL_STEP    = AW'(CONV_STRIDE);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONV_ISSUE = 3'd1,
        CONV_WAIT  = 3'd2,
        POOL_ISSUE = 3'd3,
        POOL_WAIT  = 3'd4,
        FC_ISSUE   = 3'd5,
        FC_WAIT    = 3'd6,
        FINISH     = 3'd7
    } state_t;

    state_t state_r, state_s;
    logic [FW-1:0] filter_r, pool_idx_r;
    logic [RW-1:0] row_r, col_r;
    logic [NW-1:0] fc_idx_r;
    logic busy_r, done_r, conv_go_r, pool_go_r, fc_go_r;
    logic conv_last_s, pool_last_s, fc_last_s;

    assign conv_last_s = (filter_r == FILTER_LAST) && (row_r == POS_LAST) && (col_r == POS_LAST);
    assign pool_last_s = (pool_idx_r == FILTER_LAST);
    assign fc_last_s   = (fc_idx_r == NEURON_LAST);

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; acks are only looked at in their own WAIT state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:       if (start) state_s = CONV_ISSUE; else state_s = IDLE;
            CONV_ISSUE: state_s = CONV_WAIT;
            CONV_WAIT:  if (conv_ack) state_s = conv_last_s ? POOL_ISSUE : CONV_ISSUE; else state_s = CONV_WAIT;
            POOL_ISSUE: state_s = POOL_WAIT;
            POOL_WAIT:  if (pool_ack) state_s = pool_last_s ? FC_ISSUE : POOL_ISSUE; else state_s = POOL_WAIT;
            FC_ISSUE:   state_s = FC_WAIT;
            FC_WAIT:    if (fc_ack) state_s = fc_last_s ? FINISH : FC_ISSUE; else state_s = FC_WAIT;
            FINISH:     state_s = IDLE;
            default:    state_s = IDLE;
        endcase
    end

    // Work indices advance only when the matching ack is taken, so they stay stable through WAIT
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            filter_r   <= '0;
            row_r      <= '0;
            col_r      <= '0;
            pool_idx_r <= '0;
            fc_idx_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        filter_r   <= '0;
                        row_r      <= '0;
                        col_r      <= '0;
                        pool_idx_r <= '0;
                        fc_idx_r   <= '0;
                    end
                end
                CONV_WAIT: begin
                    if (conv_ack) begin
                        if (col_r == POS_LAST) begin
                            col_r <= '0;
                            if (row_r == POS_LAST) begin
                                row_r    <= '0;
                                filter_r <= (filter_r == FILTER_LAST) ? '0 : filter_r + FILTER_ONE;
                            end else begin
                                row_r <= row_r + POS_ONE;
                            end
                        end else begin
                            col_r <= col_r + POS_ONE;
                        end
                    end
                end
                POOL_WAIT: begin
                    if (pool_ack) begin
                        pool_idx_r <= pool_last_s ? '0 : pool_idx_r + FILTER_ONE;
                    end
                end
                FC_WAIT: begin
                    if (fc_ack) begin
                        fc_idx_r <= fc_last_s ? '0 : fc_idx_r + NEURON_ONE;
                    end
                end
                FINISH: begin
                    filter_r   <= '0;
                    row_r      <= '0;
                    col_r      <= '0;
                    pool_idx_r <= '0;
                    fc_idx_r   <= '0;
                end
                default: begin
                    filter_r <= filter_r;
                end
            endcase
        end
    end

    // Status and go strobes registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            conv_go_r <= 1'b0;
            pool_go_r <= 1'b0;
            fc_go_r   <= 1'b0;
        end else begin
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == FINISH);
            conv_go_r <= (state_s == CONV_ISSUE);
            pool_go_r <= (state_s == POOL_ISSUE);
            fc_go_r   <= (state_s == FC_ISSUE);
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign conv_go         = conv_go_r;
    assign pool_go         = pool_go_r;
    assign fc_go           = fc_go_r;
    assign conv_filter_idx = filter_r;
    assign conv_row        = row_r;
    assign conv_col        = col_r;
    assign pool_filter_idx = pool_idx_r;
    assign fc_neuron_idx   = fc_idx_r;
    assign conv_base_addr  = AW'(row_r) * ROW_STEP + AW'(col_r) * COL_STEP;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cnt_r;

    // Cycle counter: cleared on an accepted start, counts every non-IDLE cycle, saturates
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            perf_cnt_r <= 32'd0;
        end else if ((state_r == IDLE) && start) begin
            perf_cnt_r <= 32'd0;
        end else if ((state_r != IDLE) && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign perf_cycles = perf_cnt_r;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
